// File: rtl/flash_pkg.sv
// Shared types and default sizing for the flash read responder slice.
package flash_pkg;
    localparam int DEF_ADDR_WIDTH  = 23;
    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_FIFO_DEPTH  = 4;
    localparam int DEF_INIT_CYCLES = 16;

    // First word address past the end of the flash store (2**23).
    localparam logic [DEF_ADDR_WIDTH:0] WORD_LIMIT = 24'h80_0000;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_DATA,
        ST_ERR
    } resp_state_t;
endpackage

// File: rtl/flash_read_responder_if.sv
// Avalon-MM pipelined read bus between the flash fetcher (master) and the responder (slave).
interface flash_read_responder_if #(
    parameter int ADDR_WIDTH = flash_pkg::DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = flash_pkg::DEF_DATA_WIDTH
);
    logic                  flash_mem_read;
    logic [ADDR_WIDTH-1:0] flash_mem_address;
    logic                  flash_mem_waitrequest;
    logic [DATA_WIDTH-1:0] flash_mem_readdata;
    logic                  flash_mem_readdatavalid;

    modport master (
        output flash_mem_read,
        output flash_mem_address,
        input  flash_mem_waitrequest,
        input  flash_mem_readdata,
        input  flash_mem_readdatavalid
    );

    modport slave (
        input  flash_mem_read,
        input  flash_mem_address,
        output flash_mem_waitrequest,
        output flash_mem_readdata,
        output flash_mem_readdatavalid
    );
endinterface

// File: rtl/flash_cmd_fifo.sv
// Small command queue of read addresses; pointers carry an extra wrap bit for full/empty.
module flash_cmd_fifo #(
    parameter int WIDTH = flash_pkg::DEF_ADDR_WIDTH,
    parameter int DEPTH = flash_pkg::DEF_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);

    logic [PW:0]      wr_ptr_reg;
    logic [PW:0]      rd_ptr_reg;
    logic [WIDTH-1:0] entries [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full    = (wr_ptr_reg[PW] != rd_ptr_reg[PW]) && (wr_ptr_reg[PW-1:0] == rd_ptr_reg[PW-1:0]);
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = entries[rd_ptr_reg[PW-1:0]];

    // Each slot is its own register so the write needs no shared array driver.
    genvar gi;
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
        logic [WIDTH-1:0] entry_reg;
        always_ff @(posedge clk) begin
            if (do_push && (wr_ptr_reg[PW-1:0] == PW'(gi))) begin
                entry_reg <= push_data;
            end
        end
        assign entries[gi] = entry_reg;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end
endmodule

// File: rtl/flash_read_responder.sv
// Avalon-MM pipelined read slave: queues read commands, serves them one at a time from the
// storage port and returns words strictly in acceptance order.
module flash_read_responder #(
    parameter int ADDR_WIDTH  = flash_pkg::DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH  = flash_pkg::DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH  = flash_pkg::DEF_FIFO_DEPTH,
    parameter int INIT_CYCLES = flash_pkg::DEF_INIT_CYCLES,
    parameter logic [ADDR_WIDTH:0] WORD_LIMIT = (ADDR_WIDTH+1)'(flash_pkg::WORD_LIMIT)
) (
    input  logic                  clk,
    input  logic                  reset,
    flash_read_responder_if.slave bus,
    output logic                  stor_read,
    output logic [ADDR_WIDTH-1:0] stor_addr,
    input  logic                  stor_ready,
    input  logic [DATA_WIDTH-1:0] stor_rdata,
    input  logic                  stor_rvalid,
    output logic                  range_err
);
    import flash_pkg::*;

    localparam int ICW = $clog2(INIT_CYCLES + 1);

    resp_state_t           state_reg;
    logic [ICW-1:0]        init_cnt_reg;
    logic [DATA_WIDTH-1:0] readdata_reg;
    logic                  readdatavalid_reg;
    logic                  stor_read_reg;
    logic [ADDR_WIDTH-1:0] stor_addr_reg;
    logic                  range_err_reg;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic [ADDR_WIDTH-1:0] fifo_head;
    logic                  waitrequest;
    logic                  push;
    logic                  pop;
    logic                  head_in_range;

    // Stall depends only on registered state, never on the incoming read.
    assign waitrequest   = (state_reg == ST_INIT) || fifo_full;
    assign push          = bus.flash_mem_read && !waitrequest;
    assign pop           = (state_reg == ST_IDLE) && !fifo_empty;
    assign head_in_range = ({1'b0, fifo_head} < WORD_LIMIT);

    flash_cmd_fifo #(
        .WIDTH (ADDR_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (bus.flash_mem_address),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg         <= ST_INIT;
            init_cnt_reg      <= '0;
            readdata_reg      <= '0;
            readdatavalid_reg <= 1'b0;
            stor_read_reg     <= 1'b0;
            stor_addr_reg     <= '0;
            range_err_reg     <= 1'b0;
        end else begin
            readdatavalid_reg <= 1'b0;
            case (state_reg)
                ST_INIT: begin
                    if (init_cnt_reg == ICW'(INIT_CYCLES - 1)) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        init_cnt_reg <= init_cnt_reg + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        if (head_in_range) begin
                            stor_read_reg <= 1'b1;
                            stor_addr_reg <= fifo_head;
                            state_reg     <= ST_ISSUE;
                        end else begin
                            state_reg <= ST_ERR;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (stor_ready) begin
                        stor_read_reg <= 1'b0;
                        state_reg     <= ST_WAIT_DATA;
                    end
                end
                ST_WAIT_DATA: begin
                    if (stor_rvalid) begin
                        readdata_reg      <= stor_rdata;
                        readdatavalid_reg <= 1'b1;
                        state_reg         <= ST_IDLE;
                    end
                end
                ST_ERR: begin
                    // Out-of-range reads still get a response so the master's count stays balanced.
                    readdata_reg      <= '0;
                    readdatavalid_reg <= 1'b1;
                    range_err_reg     <= 1'b1;
                    state_reg         <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.flash_mem_waitrequest   = waitrequest;
    assign bus.flash_mem_readdata      = readdata_reg;
    assign bus.flash_mem_readdatavalid = readdatavalid_reg;
    assign stor_read                   = stor_read_reg;
    assign stor_addr                   = stor_addr_reg;
    assign range_err                   = range_err_reg;
endmodule
